// File: rtl/uart_core_cfg.sv
// Full-duplex UART with configurable width, parity, stop bits and oversampling.
// Valid/ready handshake on both host sides; RX reports parity, framing and overrun.
module uart_core_cfg #(
  parameter int unsigned CLK_FREQ   = 25000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 txd,
  input  logic                 rxd,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun
);

  localparam int unsigned DIV   = (CLK_FREQ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned OS_W  = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W = 4;
  localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]  OS_HALF  = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic             ODD      = (PARITY == 32'd1);
  localparam logic             STOP_LST = 1'(STOP_BITS - 1);

  if (DIV < 1) begin : g_chk_div
    $error("uart_core_cfg: DIV below 1");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_bits
    $error("uart_core_cfg: DATA_BITS out of range");
  end
  if (PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_frame
    $error("uart_core_cfg: illegal PARITY or STOP_BITS");
  end
  if (OVERSAMPLE < 8 || (OVERSAMPLE & (OVERSAMPLE - 1)) != 0) begin : g_chk_os
    $error("uart_core_cfg: OVERSAMPLE must be a power of 2, at least 8");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  // Shared sample-tick divider
  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  assign tick = (div_cnt == DIV_W'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

  // ---------------- Transmitter ----------------
  state_t                tx_state, tx_state_n;
  logic [OS_W-1:0]       tx_os, tx_os_n;
  logic [BIT_W-1:0]      tx_bit, tx_bit_n;
  logic                  tx_stop, tx_stop_n;
  logic [DATA_BITS-1:0]  tx_shift, tx_shift_n;
  logic                  tx_par, tx_par_n;
  logic                  txd_n, tx_ready_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= S_IDLE;
      tx_os    <= '0;
      tx_bit   <= '0;
      tx_stop  <= 1'b0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      txd      <= 1'b1;
      tx_ready <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_os    <= tx_os_n;
      tx_bit   <= tx_bit_n;
      tx_stop  <= tx_stop_n;
      tx_shift <= tx_shift_n;
      tx_par   <= tx_par_n;
      txd      <= txd_n;
      tx_ready <= tx_ready_n;
    end
  end

  // txd is registered from the next-state decision so each bit spans exactly OVERSAMPLE ticks
  always_comb begin
    tx_state_n = tx_state;
    tx_os_n    = tx_os;
    tx_bit_n   = tx_bit;
    tx_stop_n  = tx_stop;
    tx_shift_n = tx_shift;
    tx_par_n   = tx_par;
    txd_n      = txd;
    tx_ready_n = tx_ready;
    case (tx_state)
      S_IDLE: begin
        txd_n      = 1'b1;
        tx_ready_n = 1'b1;
        if (tx_valid && tx_ready) begin
          tx_shift_n = tx_data;
          tx_par_n   = (^tx_data) ^ ODD;
          tx_os_n    = '0;
          tx_state_n = S_START;
          txd_n      = 1'b0;
          tx_ready_n = 1'b0;
        end
      end
      S_START: begin
        if (tick) begin
          tx_os_n = tx_os + 1'b1;
          if (tx_os == OS_LAST) begin
            tx_state_n = S_DATA;
            tx_bit_n   = '0;
            txd_n      = tx_shift[0];
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          tx_os_n = tx_os + 1'b1;
          if (tx_os == OS_LAST) begin
            if (tx_bit == BIT_LAST) begin
              if (PARITY != 0) begin
                tx_state_n = S_PAR;
                txd_n      = tx_par;
              end else begin
                tx_state_n = S_STOP;
                tx_stop_n  = 1'b0;
                txd_n      = 1'b1;
              end
            end else begin
              tx_bit_n   = tx_bit + 1'b1;
              tx_shift_n = tx_shift >> 1;
              txd_n      = tx_shift[1];
            end
          end
        end
      end
      S_PAR: begin
        if (tick) begin
          tx_os_n = tx_os + 1'b1;
          if (tx_os == OS_LAST) begin
            tx_state_n = S_STOP;
            tx_stop_n  = 1'b0;
            txd_n      = 1'b1;
          end
        end
      end
      S_STOP: begin
        txd_n = 1'b1;
        if (tick) begin
          tx_os_n = tx_os + 1'b1;
          if (tx_os == OS_LAST) begin
            if (tx_stop == STOP_LST) begin
              tx_state_n = S_IDLE;
              tx_ready_n = 1'b1;
            end else begin
              tx_stop_n = 1'b1;
            end
          end
        end
      end
      default: begin
        tx_state_n = S_IDLE;
        txd_n      = 1'b1;
        tx_ready_n = 1'b1;
      end
    endcase
  end

  // ---------------- Receiver ----------------
  logic rx_s1, rxs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      rx_s1 <= rxd;
      rxs   <= rx_s1;
    end
  end

  state_t               rx_state, rx_state_n;
  logic [OS_W-1:0]      rx_os, rx_os_n;
  logic [BIT_W-1:0]     rx_bit, rx_bit_n;
  logic [DATA_BITS-1:0] rx_shift, rx_shift_n;
  logic                 rx_perr, rx_perr_n;
  logic                 rx_armed, rx_armed_n;
  logic                 done_c, ferr_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state <= S_IDLE;
      rx_os    <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_perr  <= 1'b0;
      rx_armed <= 1'b1;
    end else begin
      rx_state <= rx_state_n;
      rx_os    <= rx_os_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
      rx_perr  <= rx_perr_n;
      rx_armed <= rx_armed_n;
    end
  end

  // A low stop bit disarms start detection until the line has been seen high again
  always_comb begin
    rx_state_n = rx_state;
    rx_os_n    = rx_os;
    rx_bit_n   = rx_bit;
    rx_shift_n = rx_shift;
    rx_perr_n  = rx_perr;
    rx_armed_n = rx_armed;
    done_c     = 1'b0;
    ferr_c     = 1'b0;
    case (rx_state)
      S_IDLE: begin
        if (rxs) begin
          rx_armed_n = 1'b1;
        end else if (rx_armed) begin
          rx_state_n = S_START;
          rx_os_n    = '0;
        end
      end
      S_START: begin
        if (tick) begin
          rx_os_n = rx_os + 1'b1;
          if (rx_os == OS_HALF) begin
            rx_os_n = '0;
            if (rxs) begin
              rx_state_n = S_IDLE;
            end else begin
              rx_state_n = S_DATA;
              rx_bit_n   = '0;
              rx_perr_n  = 1'b0;
            end
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          rx_os_n = rx_os + 1'b1;
          if (rx_os == OS_LAST) begin
            rx_shift_n = {rxs, rx_shift[DATA_BITS-1:1]};
            rx_bit_n   = rx_bit + 1'b1;
            if (rx_bit == BIT_LAST) begin
              rx_state_n = (PARITY != 0) ? S_PAR : S_STOP;
            end
          end
        end
      end
      S_PAR: begin
        if (tick) begin
          rx_os_n = rx_os + 1'b1;
          if (rx_os == OS_LAST) begin
            rx_perr_n  = rxs ^ (^rx_shift) ^ ODD;
            rx_state_n = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          rx_os_n = rx_os + 1'b1;
          if (rx_os == OS_LAST) begin
            done_c     = 1'b1;
            ferr_c     = ~rxs;
            rx_armed_n = rxs;
            rx_state_n = S_IDLE;
          end
        end
      end
      default: rx_state_n = S_IDLE;
    endcase
  end

  // Host-side holding register: a new word only replaces the held one when the host frees it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_valid      <= 1'b0;
      rx_data       <= '0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      rx_overrun <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (done_c) begin
        if (!rx_valid || rx_ready) begin
          rx_valid      <= 1'b1;
          rx_data       <= rx_shift;
          rx_parity_err <= rx_perr;
          rx_frame_err  <= ferr_c;
        end else begin
          rx_overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_core_cfg.sv
// Directed bench for uart_core_cfg: 8N1 instance, 7E2 loopback instance, 8O1 RX instance.
module tb_uart_core_cfg;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance A: 8N1
  logic       tx_valid_a = 1'b0, tx_ready_a, txd_a, rxd_a = 1'b1;
  logic [7:0] tx_data_a = '0, rx_data_a;
  logic       rx_valid_a, rx_ready_a = 1'b0, rx_perr_a, rx_ferr_a, rx_ovr_a;

  // Instance B: 7E2, txd looped to rxd
  logic       tx_valid_b = 1'b0, tx_ready_b, txd_b;
  logic [6:0] tx_data_b = '0, rx_data_b;
  logic       rx_valid_b, rx_ready_b = 1'b0, rx_perr_b, rx_ferr_b, rx_ovr_b;

  // Instance C: 8O1, receive only
  logic       tx_ready_c, txd_c, rxd_c = 1'b1;
  logic [7:0] rx_data_c;
  logic       rx_valid_c, rx_ready_c = 1'b0, rx_perr_c, rx_ferr_c, rx_ovr_c;

  uart_core_cfg #(.CLK_FREQ(1600000), .BAUD(100000), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(1), .OVERSAMPLE(16)) u_a (
    .clk(clk), .rst(rst), .tx_valid(tx_valid_a), .tx_data(tx_data_a), .tx_ready(tx_ready_a),
    .txd(txd_a), .rxd(rxd_a), .rx_valid(rx_valid_a), .rx_ready(rx_ready_a), .rx_data(rx_data_a),
    .rx_parity_err(rx_perr_a), .rx_frame_err(rx_ferr_a), .rx_overrun(rx_ovr_a));

  uart_core_cfg #(.CLK_FREQ(1600000), .BAUD(100000), .DATA_BITS(7), .PARITY(2),
                  .STOP_BITS(2), .OVERSAMPLE(16)) u_b (
    .clk(clk), .rst(rst), .tx_valid(tx_valid_b), .tx_data(tx_data_b), .tx_ready(tx_ready_b),
    .txd(txd_b), .rxd(txd_b), .rx_valid(rx_valid_b), .rx_ready(rx_ready_b), .rx_data(rx_data_b),
    .rx_parity_err(rx_perr_b), .rx_frame_err(rx_ferr_b), .rx_overrun(rx_ovr_b));

  uart_core_cfg #(.CLK_FREQ(1600000), .BAUD(100000), .DATA_BITS(8), .PARITY(1),
                  .STOP_BITS(1), .OVERSAMPLE(16)) u_c (
    .clk(clk), .rst(rst), .tx_valid(1'b0), .tx_data(8'h00), .tx_ready(tx_ready_c),
    .txd(txd_c), .rxd(rxd_c), .rx_valid(rx_valid_c), .rx_ready(rx_ready_c), .rx_data(rx_data_c),
    .rx_parity_err(rx_perr_c), .rx_frame_err(rx_ferr_c), .rx_overrun(rx_ovr_c));

  // Running event counters; tests take snapshots and compare differences
  int ovr_cnt = 0;
  int val_cnt = 0;
  always @(negedge clk) begin
    if (rx_ovr_a === 1'b1) ovr_cnt++;
    if (rx_valid_a === 1'b1) val_cnt++;
  end

  // Drive n serial bits (LSB first) at 16 clk each; the line is left at the last bit
  task automatic drive_rx(input int sel, input logic [11:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      if (sel == 0) rxd_a = bits[i];
      else          rxd_c = bits[i];
      repeat (16) @(negedge clk);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    total++; if (txd_a !== 1'b1) begin bad++; $display("FAIL rst_txd got=%b exp=1", txd_a); end
    total++; if (tx_ready_a !== 1'b1) begin bad++; $display("FAIL rst_tx_ready got=%b exp=1", tx_ready_a); end
    total++; if (rx_valid_a !== 1'b0) begin bad++; $display("FAIL rst_rx_valid got=%b exp=0", rx_valid_a); end
    total++; if ({rx_data_a, rx_perr_a, rx_ferr_a, rx_ovr_a} !== 11'h0) begin
      bad++; $display("FAIL rst_rx_regs got=%h exp=0", {rx_data_a, rx_perr_a, rx_ferr_a, rx_ovr_a}); end
    total++; if ({txd_b, tx_ready_b, txd_c, tx_ready_c} !== 4'hF) begin
      bad++; $display("FAIL rst_other_tx got=%b exp=1111", {txd_b, tx_ready_b, txd_c, tx_ready_c}); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_tx_8n1(input logic [7:0] v);
    logic [9:0] fr;
    int first_bad;
    fr = {1'b1, v, 1'b0};
    first_bad = -1;
    tx_valid_a = 1'b1; tx_data_a = v;
    @(negedge clk);
    tx_valid_a = 1'b0;
    for (int k = 0; k < 160; k++) begin
      if ((txd_a !== fr[k/16] || tx_ready_a !== 1'b0) && first_bad < 0) first_bad = k;
      @(negedge clk);
    end
    total++; if (first_bad !== -1) begin
      bad++; $display("FAIL tx_8n1_bits data=%h first wrong clk=%0d exp=-1", v, first_bad); end
    total++; if (tx_ready_a !== 1'b1 || txd_a !== 1'b1) begin
      bad++; $display("FAIL tx_8n1_ready160 got ready=%b txd=%b exp=1 1", tx_ready_a, txd_a); end
  endtask

  task automatic test_loopback_7e2;
    logic [10:0] fr;
    int first_bad;
    fr = {2'b11, 1'b0, 7'h55, 1'b0};
    first_bad = -1;
    tx_valid_b = 1'b1; tx_data_b = 7'h55;
    @(negedge clk);
    tx_valid_b = 1'b0;
    for (int k = 0; k < 176; k++) begin
      if ((txd_b !== fr[k/16] || tx_ready_b !== 1'b0) && first_bad < 0) first_bad = k;
      @(negedge clk);
    end
    total++; if (first_bad !== -1) begin
      bad++; $display("FAIL lb_bits first wrong clk=%0d exp=-1", first_bad); end
    total++; if (tx_ready_b !== 1'b1) begin
      bad++; $display("FAIL lb_ready176 got=%b exp=1", tx_ready_b); end
    for (int i = 0; i < 40 && rx_valid_b !== 1'b1; i++) @(negedge clk);
    total++; if (rx_valid_b !== 1'b1 || rx_data_b !== 7'h55) begin
      bad++; $display("FAIL lb_rx got valid=%b data=%h exp=1 55", rx_valid_b, rx_data_b); end
    total++; if ({rx_perr_b, rx_ferr_b, rx_ovr_b} !== 3'b000) begin
      bad++; $display("FAIL lb_flags got=%b exp=000", {rx_perr_b, rx_ferr_b, rx_ovr_b}); end
    rx_ready_b = 1'b1; @(negedge clk); rx_ready_b = 1'b0;
    total++; if (rx_valid_b !== 1'b0) begin
      bad++; $display("FAIL lb_consume got=%b exp=0", rx_valid_b); end
  endtask

  task automatic test_parity_8o1;
    drive_rx(1, {1'b1, 1'b0, 8'h3C, 1'b0}, 11);
    for (int i = 0; i < 40 && rx_valid_c !== 1'b1; i++) @(negedge clk);
    total++; if (rx_valid_c !== 1'b1 || rx_data_c !== 8'h3C) begin
      bad++; $display("FAIL par_bad_rx got valid=%b data=%h exp=1 3c", rx_valid_c, rx_data_c); end
    total++; if ({rx_perr_c, rx_ferr_c} !== 2'b10) begin
      bad++; $display("FAIL par_bad_flags got=%b exp=10", {rx_perr_c, rx_ferr_c}); end
    rx_ready_c = 1'b1; @(negedge clk); rx_ready_c = 1'b0;
    repeat (16) @(negedge clk);
    drive_rx(1, {1'b1, 1'b1, 8'h3C, 1'b0}, 11);
    for (int i = 0; i < 40 && rx_valid_c !== 1'b1; i++) @(negedge clk);
    total++; if (rx_valid_c !== 1'b1 || {rx_perr_c, rx_ferr_c} !== 2'b00) begin
      bad++; $display("FAIL par_good got valid=%b flags=%b exp=1 00", rx_valid_c, {rx_perr_c, rx_ferr_c}); end
    rx_ready_c = 1'b1; @(negedge clk); rx_ready_c = 1'b0;
  endtask

  task automatic test_frame_err;
    int snap;
    drive_rx(0, {2'b00, 1'b0, 8'h81, 1'b0}, 10);
    for (int i = 0; i < 40 && rx_valid_a !== 1'b1; i++) @(negedge clk);
    total++; if (rx_valid_a !== 1'b1 || rx_data_a !== 8'h81) begin
      bad++; $display("FAIL ferr_rx got valid=%b data=%h exp=1 81", rx_valid_a, rx_data_a); end
    total++; if ({rx_perr_a, rx_ferr_a} !== 2'b01) begin
      bad++; $display("FAIL ferr_flags got=%b exp=01", {rx_perr_a, rx_ferr_a}); end
    rx_ready_a = 1'b1; @(negedge clk); rx_ready_a = 1'b0;
    snap = val_cnt;
    repeat (200) @(negedge clk);
    total++; if (val_cnt - snap !== 0) begin
      bad++; $display("FAIL ferr_break_rearm got valid cycles=%0d exp=0", val_cnt - snap); end
    rxd_a = 1'b1;
    repeat (32) @(negedge clk);
  endtask

  task automatic test_glitch;
    int snap;
    snap = val_cnt;
    rxd_a = 1'b0;
    repeat (6) @(negedge clk);
    rxd_a = 1'b1;
    repeat (40) @(negedge clk);
    total++; if (val_cnt - snap !== 0) begin
      bad++; $display("FAIL glitch_output got valid cycles=%0d exp=0", val_cnt - snap); end
    drive_rx(0, {2'b11, 1'b1, 8'h12, 1'b0}, 10);
    for (int i = 0; i < 40 && rx_valid_a !== 1'b1; i++) @(negedge clk);
    total++; if (rx_valid_a !== 1'b1 || rx_data_a !== 8'h12 || rx_ferr_a !== 1'b0) begin
      bad++; $display("FAIL glitch_then_frame got valid=%b data=%h ferr=%b exp=1 12 0",
                      rx_valid_a, rx_data_a, rx_ferr_a); end
    rx_ready_a = 1'b1; @(negedge clk); rx_ready_a = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_overrun;
    int snap;
    snap = ovr_cnt;
    drive_rx(0, {2'b11, 1'b1, 8'h11, 1'b0}, 10);
    for (int i = 0; i < 40 && rx_valid_a !== 1'b1; i++) @(negedge clk);
    total++; if (rx_valid_a !== 1'b1 || rx_data_a !== 8'h11) begin
      bad++; $display("FAIL ovr_first got valid=%b data=%h exp=1 11", rx_valid_a, rx_data_a); end
    drive_rx(0, {2'b11, 1'b1, 8'h22, 1'b0}, 10);
    repeat (40) @(negedge clk);
    total++; if (ovr_cnt - snap !== 1) begin
      bad++; $display("FAIL ovr_pulse got cycles=%0d exp=1", ovr_cnt - snap); end
    total++; if (rx_valid_a !== 1'b1 || rx_data_a !== 8'h11) begin
      bad++; $display("FAIL ovr_held got valid=%b data=%h exp=1 11", rx_valid_a, rx_data_a); end
    rx_ready_a = 1'b1; @(negedge clk); rx_ready_a = 1'b0;
    total++; if (rx_valid_a !== 1'b0) begin
      bad++; $display("FAIL ovr_consume got=%b exp=0", rx_valid_a); end
  endtask

  task automatic test_reset_mid_tx;
    tx_valid_a = 1'b1; tx_data_a = 8'h00;
    @(negedge clk);
    tx_valid_a = 1'b0;
    repeat (50) @(negedge clk);
    total++; if (txd_a !== 1'b0 || tx_ready_a !== 1'b0) begin
      bad++; $display("FAIL midtx_busy got txd=%b ready=%b exp=0 0", txd_a, tx_ready_a); end
    rst = 1'b1;
    #1;
    total++; if (txd_a !== 1'b1 || tx_ready_a !== 1'b1) begin
      bad++; $display("FAIL midtx_reset got txd=%b ready=%b exp=1 1", txd_a, tx_ready_a); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_tx_8n1(8'hA5);
  endtask

  initial begin
    test_reset();
    test_tx_8n1(8'hA5);
    test_loopback_7e2();
    test_parity_8o1();
    test_frame_err();
    test_glitch();
    test_overrun();
    test_reset_mid_tx();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
